sum_frame_accumulator: RTL
==========================

Name: sum_frame_accumulator

Overview:
- Downstream consumer of the registered 4-bit adder stage: takes its 5-bit sum stream and accumulates FRAME_LEN samples into a frame total and mean.
- Presents the result on a valid/ready output port and holds it until it is taken.
- Provides an early-close (flush) path for partial frames.
- Sits between the adder stage and any result sink or bus interface.

Parameters:
- IN_W, 5, width of incoming sum samples.
- FRAME_LEN, 4, samples per full frame; power of two, at least 2.
- LOG2_LEN, $clog2(FRAME_LEN), shift amount for mean (derived).
- ACC_W, IN_W+LOG2_LEN, accumulator and total width (derived).
- CNT_W, LOG2_LEN+1, width of sample count, holds 1..FRAME_LEN (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_data  in  IN_W  sample value (unsigned).
- in_ready  out  1  block can accept a sample.
- flush  in  1  close the current frame early.
- out_valid  out  1  frame result present.
- out_ready  in  1  sink accepts the result.
- out_total  out  ACC_W  sum of the frame's samples.
- out_mean  out  IN_W  out_total >> LOG2_LEN.
- out_count  out  CNT_W  samples in the frame.
- out_partial  out  1  frame closed by flush before FRAME_LEN samples.
- out_min, out_max  out  IN_W  only with SUM_ACC_MINMAX_EN.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=ACCUM, acc=0, cnt=0. All outputs are 0 except in_ready=1.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept rule: a sample is accepted when in_valid && in_ready. On accept, acc<=acc+in_data and cnt<=cnt+1.
- Frame close, full: an accept with cnt==FRAME_LEN-1 closes the frame.
- Frame close, flush: flush in ACCUM with (cnt>0 or a same-cycle accept) closes the frame.
  - A beat accepted in the same cycle as flush is included in the frame.
- On close:
  - Register out_total = acc + beat, out_count = cnt + beat, out_mean = out_total>>LOG2_LEN.
  - out_partial = (out_count != FRAME_LEN).
  - Enter HOLD. out_valid rises the cycle after the closing edge (1-cycle latency).
  - The mean of a partial frame is still divided by FRAME_LEN (not by out_count).
- Full close coinciding with flush: treated as a full close, out_partial=0.
- Flush ignored: in ACCUM with cnt==0 and no accept; and in HOLD.
- HOLD behaviour:
  - All out_* are stable while out_valid && !out_ready.
  - On out_ready: go to ACCUM, clear acc and cnt, out_valid<=0.
  - There is a one-cycle bubble: in_ready returns the cycle after the handshake.
- Overflow: none possible. Max total FRAME_LEN*(2^IN_W-1) fits ACC_W (124 < 128 at defaults).
- Reset mid-frame or in HOLD: the partial frame or pending result is discarded and all reset values apply the next cycle.
- in_data is ignored when in_valid=0. Inputs are treated as synchronous to clk.

Optional Feature:
- Macro: SUM_ACC_MINMAX_EN.
- Defined:
  - out_min and out_max ports exist and track the running min and max over the frame.
  - The first accepted beat initialises both.
  - They are registered at close and held in HOLD. Reset value is 0.
- Undefined: the ports and tracking logic are absent; all other behaviour is identical.

Decomposition:
- Package sum_acc_pkg holds:
  - state encoding constants ST_ACCUM=1'b0, ST_HOLD=1'b1;
  - default IN_W and FRAME_LEN;
  - a clog2 helper function for derived widths.
- Sub-module sum_acc_minmax (running min/max tracker with init-on-first-beat). It is instantiated only under SUM_ACC_MINMAX_EN.

Test Plan:
- Full frame: accept 7,15,20,30 on consecutive cycles -> out_valid one cycle after the 4th accept; total=72, mean=18, count=4, partial=0.
- Maximum value: accept 31,31,31,31 -> total=124, mean=31, no wrap.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and in_data=9 -> outputs unchanged, in_ready=0, no sample consumed.
- Release: after out_ready=1, the first accept is one cycle later.
- Flush: accept 3, then 9 with flush=1 in the same cycle -> total=12, count=2, partial=1, mean=3.
- Flush with cnt==0 and no beat -> no out_valid.
- Reset mid-frame: accept 5,5, assert rst one cycle, then accept 1,1,1,1 -> total=4, count=4.
- MINMAX_EN build: accept 20,3,30,7 -> min=3, max=30, total=60, mean=15.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// Shared types, defaults and width helper for the sum frame accumulator.
// Optional min/max tracking is enabled by defining SUM_ACC_MINMAX_EN.
package sum_acc_pkg;

  localparam int DEF_IN_W      = 5;
  localparam int DEF_FRAME_LEN = 4;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sum_acc_minmax.sv
// Running min/max tracker; the first beat of a frame (first=1) reloads both.
// Only instantiated when SUM_ACC_MINMAX_EN is defined.
module sum_acc_minmax
  import sum_acc_pkg::*;
#(
  parameter int IN_W = DEF_IN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            accept,
  input  logic            first,
  input  logic [IN_W-1:0] data,
  output logic [IN_W-1:0] next_min,
  output logic [IN_W-1:0] next_max
);

  logic [IN_W-1:0] run_min;
  logic [IN_W-1:0] run_max;

  // next_* already folds in the current beat, so the top can register it at close.
  always_comb begin
    next_min = run_min;
    next_max = run_max;
    if (accept) begin
      if (first) begin
        next_min = data;
        next_max = data;
      end else begin
        next_min = (data < run_min) ? data : run_min;
        next_max = (data > run_max) ? data : run_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min <= '0;
      run_max <= '0;
    end else begin
      run_min <= next_min;
      run_max <= next_max;
    end
  end

endmodule

// File: rtl/sum_frame_accumulator.sv
// Accumulates FRAME_LEN samples into a total/mean held on a valid/ready port.
// Define SUM_ACC_MINMAX_EN to add out_min/out_max frame tracking.
module sum_frame_accumulator
  import sum_acc_pkg::*;
#(
  parameter  int IN_W      = DEF_IN_W,
  parameter  int FRAME_LEN = DEF_FRAME_LEN,
  localparam int LOG2_LEN  = clog2(FRAME_LEN),
  localparam int ACC_W     = IN_W + LOG2_LEN,
  localparam int CNT_W     = LOG2_LEN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [IN_W-1:0]  out_mean,
  output logic [CNT_W-1:0] out_count,
  output logic             out_partial
`ifdef SUM_ACC_MINMAX_EN
  ,
  output logic [IN_W-1:0]  out_min,
  output logic [IN_W-1:0]  out_max
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and out_* stay stable while out_valid && !out_ready.

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             close;
  logic [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_next;

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign sum_next  = acc + (accept ? ACC_W'(in_data) : '0);
  assign cnt_next  = cnt + CNT_W'(accept);
  // Full close wins over flush; flush needs something in the frame to close.
  assign close     = in_ready && ((accept && (cnt == CNT_W'(FRAME_LEN - 1)))
                                  || (flush && ((cnt != '0) || accept)));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACCUM: if (close)     state_next = ST_HOLD;
      ST_HOLD:  if (out_ready) state_next = ST_ACCUM;
      default:                 state_next = ST_ACCUM;
    endcase
  end

`ifdef SUM_ACC_MINMAX_EN
  logic [IN_W-1:0] mm_next_min;
  logic [IN_W-1:0] mm_next_max;

  sum_acc_minmax #(.IN_W(IN_W)) u_minmax (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .first    (cnt == '0),
    .data     (in_data),
    .next_min (mm_next_min),
    .next_max (mm_next_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_min <= '0;
      out_max <= '0;
    end else if (close) begin
      out_min <= mm_next_min;
      out_max <= mm_next_max;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      out_total   <= '0;
      out_mean    <= '0;
      out_count   <= '0;
      out_partial <= 1'b0;
    end else if (state == ST_HOLD) begin
      if (out_ready) begin
        acc <= '0;
        cnt <= '0;
      end
    end else begin
      if (accept) begin
        acc <= sum_next;
        cnt <= cnt_next;
      end
      if (close) begin
        out_total   <= sum_next;
        out_mean    <= sum_next[ACC_W-1:LOG2_LEN];
        out_count   <= cnt_next;
        out_partial <= (cnt_next != CNT_W'(FRAME_LEN));
      end
    end
  end

endmodule
